// File: rtl/window_result_writer_if.sv
// Result stream and RAM write bus for window_result_writer.
// The slave view belongs to the writer: it takes the result stream in and
// drives the RAM write port. The master view belongs to the environment.
interface window_result_writer_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int DATA_ADDR_WIDTH = 10
);
    logic                       in_bit;
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_ADDR_WIDTH-1:0] ram_w_addr;
    logic [DATA_WIDTH-1:0]      ram_w_data;
    logic                       ram_w_en;

    modport master (
        output in_bit,
        output in_valid,
        input  in_ready,
        input  ram_w_addr,
        input  ram_w_data,
        input  ram_w_en
    );

    modport slave (
        input  in_bit,
        input  in_valid,
        output in_ready,
        output ram_w_addr,
        output ram_w_data,
        output ram_w_en
    );
endinterface

// File: rtl/window_result_writer.sv
// window_result_writer: packs one result bit per window position (raster
// order, LSB first) into RAM words and writes them from BASE_ADDR upward.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, RAM port quiet
// COLLECT | accepting result bits into the pack register
// WRITE   | one-cycle RAM write of the completed (or final partial) word
// DONE    | one-cycle completion pulse, address returns to BASE_ADDR
module window_result_writer #(
    parameter int DATA_WIDTH      = 8,
    parameter int DATA_ADDR_WIDTH = 10,
    parameter int IMAGE_ROW_LEN   = 32,
    parameter int IMAGE_COL_LEN   = 32,
    parameter int KERNEL_SIZE     = 3,
    parameter int STRIDE          = 1,
    parameter int BASE_ADDR       = 0,
    localparam int OUT_ROW_LEN    = (IMAGE_ROW_LEN - KERNEL_SIZE) / STRIDE + 1,
    localparam int OUT_COL_LEN    = (IMAGE_COL_LEN - KERNEL_SIZE) / STRIDE + 1,
    localparam int ROW_W          = $clog2(OUT_ROW_LEN + 1),
    localparam int COL_W          = $clog2(OUT_COL_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    window_result_writer_if.slave bus,
    output logic [ROW_W-1:0]      out_row,
    output logic [COL_W-1:0]      out_col,
    output logic                  busy,
    output logic                  done
);

    localparam int TOTAL  = OUT_ROW_LEN * OUT_COL_LEN;
    localparam int NWORDS = (TOTAL + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [CNT_W-1:0]           LAST_RES = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0]           ALL_RES  = CNT_W'(TOTAL);
    localparam logic [BIT_W-1:0]           LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [COL_W-1:0]           LAST_COL = COL_W'(OUT_COL_LEN - 1);
    localparam logic [DATA_ADDR_WIDTH-1:0] BASE     = DATA_ADDR_WIDTH'(BASE_ADDR);

    // The whole output map has to land inside the RAM without wrapping.
    generate
        if (BASE_ADDR + NWORDS > (1 << DATA_ADDR_WIDTH)) begin : g_addr_range_check
            $error("window_result_writer: BASE_ADDR + NWORDS exceeds RAM depth");
        end
    endgenerate

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] pack;
    logic [DATA_WIDTH-1:0] next_pack;
    logic [BIT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      res_cnt;
    logic                  word_full;
    logic                  last_res;

    assign word_full = (bit_cnt == LAST_BIT);
    assign last_res  = (res_cnt == LAST_RES);

    // Moore-decoded status; nothing here depends on in_valid.
    assign bus.in_ready = (state == S_COLLECT);
    assign busy         = (state == S_COLLECT) || (state == S_WRITE);
    assign done         = (state == S_DONE);

    // Pack register with the incoming bit merged at the current position;
    // unfilled upper bits stay 0 because pack is cleared per word.
    always_comb begin
        next_pack          = pack;
        next_pack[bit_cnt] = bus.in_bit;
    end

    // Sequencer, packer, raster position and RAM write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            pack           <= '0;
            bit_cnt        <= '0;
            res_cnt        <= '0;
            out_row        <= '0;
            out_col        <= '0;
            bus.ram_w_addr <= BASE;
            bus.ram_w_data <= '0;
            bus.ram_w_en   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_COLLECT;
                        pack           <= '0;
                        bit_cnt        <= '0;
                        res_cnt        <= '0;
                        out_row        <= '0;
                        out_col        <= '0;
                        bus.ram_w_addr <= BASE;
                    end
                end
                S_COLLECT: begin
                    if (bus.in_valid) begin
                        pack    <= next_pack;
                        bit_cnt <= bit_cnt + 1'b1;
                        res_cnt <= res_cnt + 1'b1;
                        if (out_col == LAST_COL) begin
                            out_col <= '0;
                            out_row <= out_row + 1'b1;
                        end else begin
                            out_col <= out_col + 1'b1;
                        end
                        if (word_full || last_res) begin
                            state          <= S_WRITE;
                            bus.ram_w_data <= next_pack;
                            bus.ram_w_en   <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    bus.ram_w_en   <= 1'b0;
                    bus.ram_w_addr <= bus.ram_w_addr + 1'b1;
                    pack           <= '0;
                    bit_cnt        <= '0;
                    state          <= (res_cnt == ALL_RES) ? S_DONE : S_COLLECT;
                end
                S_DONE: begin
                    state          <= S_IDLE;
                    bus.ram_w_addr <= BASE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_result_writer.sv
// Self-checking bench for window_result_writer: a default-sized instance
// and an 8x8 / stride 2 / base 16 instance. Expected words come from the
// bit sequence fed in, packed with plain arithmetic.
module tb_window_result_writer;

    localparam int A_OUT    = (32 - 3) / 1 + 1;
    localparam int A_TOTAL  = A_OUT * A_OUT;
    localparam int A_NWORDS = (A_TOTAL + 7) / 8;

    logic clk;
    logic rst;
    logic start_a;
    logic start_b;

    logic [4:0] out_row_a;
    logic [4:0] out_col_a;
    logic       busy_a;
    logic       done_a;
    logic [1:0] out_row_b;
    logic [1:0] out_col_b;
    logic       busy_b;
    logic       done_b;

    window_result_writer_if ifa ();
    window_result_writer_if ifb ();

    window_result_writer dut_a (
        .clk     (clk),
        .rst     (rst),
        .start   (start_a),
        .bus     (ifa),
        .out_row (out_row_a),
        .out_col (out_col_a),
        .busy    (busy_a),
        .done    (done_a)
    );

    window_result_writer #(
        .IMAGE_ROW_LEN (8),
        .IMAGE_COL_LEN (8),
        .KERNEL_SIZE   (3),
        .STRIDE        (2),
        .BASE_ADDR     (16)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .start   (start_b),
        .bus     (ifb),
        .out_row (out_row_b),
        .out_col (out_col_b),
        .busy    (busy_b),
        .done    (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    bit bits_a [A_TOTAL];

    logic [9:0] wa_addr [$];
    logic [7:0] wa_data [$];
    logic [9:0] wb_addr [$];
    logic [7:0] wb_data [$];
    int cyc        = 0;
    int t_busy     = 0;
    int t_done     = 0;
    int t_lastwr   = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int viol       = 0;
    bit busy_prev  = 1'b0;

    // Write/done monitor, sampled on the falling edge.
    always begin
        @(negedge clk);
        cyc = cyc + 1;
        if (ifa.ram_w_en === 1'b1) begin
            wa_addr.push_back(ifa.ram_w_addr);
            wa_data.push_back(ifa.ram_w_data);
            t_lastwr = cyc;
            if (ifa.in_ready === 1'b1) viol = viol + 1;
        end
        if (busy_a === 1'b1 && !busy_prev) t_busy = cyc;
        busy_prev = (busy_a === 1'b1);
        if (done_a === 1'b1) begin
            done_cnt_a = done_cnt_a + 1;
            t_done = cyc;
        end
        if (ifb.ram_w_en === 1'b1) begin
            wb_addr.push_back(ifb.ram_w_addr);
            wb_data.push_back(ifb.ram_w_data);
        end
        if (done_b === 1'b1) done_cnt_b = done_cnt_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] exp_word(input int w);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (w * 8 + i < A_TOTAL) r[i] = bits_a[w * 8 + i];
        return r;
    endfunction

    task automatic clear_mon();
        wa_addr.delete();
        wa_data.delete();
        wb_addr.delete();
        wb_data.delete();
        done_cnt_a = 0;
        done_cnt_b = 0;
        viol = 0;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    // Feed nbits of bits_a with in_valid high pvalid% of cycles; the raster
    // position is checked against the count of accepted bits every cycle.
    task automatic feed_a(input int nbits, input int pvalid, input bit spam);
        int  idx;
        int  guard;
        bit  v;
        idx = 0;
        guard = 0;
        while (idx < nbits && guard < 20000) begin
            chk("raster_row", 32'(out_row_a), 32'(idx / A_OUT));
            chk("raster_col", 32'(out_col_a), 32'(idx % A_OUT));
            v = ($urandom_range(99) < pvalid);
            ifa.in_valid = v;
            if (v && ifa.in_ready === 1'b1) ifa.in_bit = bits_a[idx];
            else ifa.in_bit = 1'($urandom_range(1));
            if (spam) start_a = 1'($urandom_range(1));
            if (v && ifa.in_ready === 1'b1) idx++;
            @(posedge clk); #1;
            guard++;
        end
        ifa.in_valid = 1'b0;
        start_a = 1'b0;
        chk("feed_accepted", idx, nbits);
        chk("raster_row_end", 32'(out_row_a), 32'(idx / A_OUT));
        chk("raster_col_end", 32'(out_col_a), 32'(idx % A_OUT));
    endtask

    task automatic wait_done_a(input bit start_in_done);
        int  guard;
        bit  seen;
        guard = 0;
        seen = 1'b0;
        while (!seen && guard < 50) begin
            if (done_a === 1'b1) begin
                seen = 1'b1;
                if (start_in_done) start_a = 1'b1;
            end
            @(posedge clk); #1;
            guard++;
        end
        start_a = 1'b0;
        chk("done_seen", 32'(seen), 1);
    endtask

    task automatic check_writes_a(input int nwords);
        chk("write_count", wa_addr.size(), nwords);
        for (int w = 0; w < nwords && w < wa_addr.size(); w++) begin
            chk($sformatf("wr_addr[%0d]", w), 32'(wa_addr[w]), w);
            chk($sformatf("wr_data[%0d]", w), 32'(wa_data[w]), 32'(exp_word(w)));
        end
    endtask

    initial begin
        int guard;
        int nacc;
        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        ifa.in_bit = 1'b0;
        ifa.in_valid = 1'b0;
        ifb.in_bit = 1'b0;
        ifb.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state of both instances.
        chk("rst_in_ready", 32'(ifa.in_ready), 0);
        chk("rst_w_en", 32'(ifa.ram_w_en), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_addr", 32'(ifa.ram_w_addr), 0);
        chk("rst_data", 32'(ifa.ram_w_data), 0);
        chk("rst_row", 32'(out_row_a), 0);
        chk("rst_col", 32'(out_col_a), 0);
        chk("rst_addr_b", 32'(ifb.ram_w_addr), 16);
        rst = 1'b1;
        @(posedge clk); #1;

        // Map 1: alternating bits, in_valid held high.
        for (int i = 0; i < A_TOTAL; i++) bits_a[i] = (i % 2 == 0);
        clear_mon();
        pulse_start_a();
        chk("start_busy", 32'(busy_a), 1);
        chk("start_in_ready", 32'(ifa.in_ready), 1);
        feed_a(A_TOTAL, 100, 1'b0);
        wait_done_a(1'b0);
        check_writes_a(A_NWORDS);
        if (wa_data.size() == A_NWORDS) begin
            chk("word0_const", 32'(wa_data[0]), 32'h55);
            chk("word_last_const", 32'(wa_data[A_NWORDS-1]), 32'h05);
        end
        chk("map_cycles", t_done - t_busy, 1013);
        chk("done_after_write", t_done, t_lastwr + 1);
        chk("done_count", done_cnt_a, 1);
        chk("wen_with_ready", viol, 0);
        chk("addr_back_base", 32'(ifa.ram_w_addr), 0);

        // Map 2: same bits, in_valid randomly dropped.
        clear_mon();
        pulse_start_a();
        feed_a(A_TOTAL, 50, 1'b0);
        wait_done_a(1'b0);
        check_writes_a(A_NWORDS);
        chk("done_count_2", done_cnt_a, 1);
        chk("wen_with_ready_2", viol, 0);

        // Map 3: random bits, reset after 20 accepted bits.
        for (int i = 0; i < A_TOTAL; i++) bits_a[i] = 1'($urandom_range(1));
        clear_mon();
        pulse_start_a();
        feed_a(20, 50, 1'b0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy_a), 0);
        chk("abort_w_en", 32'(ifa.ram_w_en), 0);
        chk("abort_row", 32'(out_row_a), 0);
        chk("abort_col", 32'(out_col_a), 0);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_writes_a(2);
        chk("abort_done", done_cnt_a, 0);

        // Map 4: fresh random bits, random valid, start spammed mid-map and in DONE.
        for (int i = 0; i < A_TOTAL; i++) bits_a[i] = 1'($urandom_range(1));
        clear_mon();
        pulse_start_a();
        chk("restart_addr", 32'(ifa.ram_w_addr), 0);
        chk("restart_row", 32'(out_row_a), 0);
        chk("restart_col", 32'(out_col_a), 0);
        feed_a(A_TOTAL, 70, 1'b1);
        wait_done_a(1'b1);
        repeat (6) @(posedge clk);
        #1;
        check_writes_a(A_NWORDS);
        chk("done_count_4", done_cnt_a, 1);
        chk("idle_after_done", 32'(busy_a), 0);
        chk("wen_with_ready_4", viol, 0);

        // Small map: 8x8, kernel 3, stride 2, base 16, nine ones.
        clear_mon();
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        nacc = 0;
        guard = 0;
        while (nacc < 9 && guard < 100) begin
            ifb.in_valid = 1'b1;
            ifb.in_bit = 1'b1;
            if (ifb.in_ready === 1'b1) nacc++;
            @(posedge clk); #1;
            guard++;
        end
        ifb.in_valid = 1'b0;
        chk("b_accepted", nacc, 9);
        chk("b_row_end", 32'(out_row_b), 3);
        chk("b_col_end", 32'(out_col_b), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("b_write_count", wb_addr.size(), 2);
        if (wb_addr.size() >= 2) begin
            chk("b_addr0", 32'(wb_addr[0]), 16);
            chk("b_data0", 32'(wb_data[0]), 32'hFF);
            chk("b_addr1", 32'(wb_addr[1]), 17);
            chk("b_data1", 32'(wb_data[1]), 32'h01);
        end
        chk("b_done_count", done_cnt_b, 1);
        chk("b_idle", 32'(busy_b), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
